// File: rtl/hpi_access_sequencer.sv
// hpi_access_sequencer
//   Drives one CY7C67200 HPI bus cycle per accepted command, with
//   programmable setup, strobe, hold and recovery phases. Every pin-facing
//   output comes straight from a flop, so strobes cannot glitch.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata command fields, latched on accept
//   rsp_valid                     one-cycle pulse per completed command
//   rsp_rdata                     last read value, held until the next read
//   busy                          high whenever a command is in flight
//   otg_addr, otg_cs_n,
//   otg_rd_n, otg_wr_n            HPI address and control pins
//   otg_data_out, otg_data_oe     write data and pad output enable
//   otg_data_in                   read data from the pad
module hpi_access_sequencer #(
    parameter int CNT_W       = 4,
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             write_reg, write_next;

    logic             accept;
    logic             phase_done;
    logic             window_next;
    logic             capture;

    // The pins are registered, so their next values are derived from the
    // state being entered rather than the state being left.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        accept      = cmd_valid && cmd_ready && (state_reg == IDLE);
        phase_done  = (cnt_reg == '0);
        write_next  = accept ? cmd_write : write_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                    cnt_next   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_next = STROBE;
                    cnt_next   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            STROBE: begin
                if (phase_done) begin
                    state_next = HOLD;
                    cnt_next   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            HOLD: begin
                if (phase_done) begin
                    state_next = RECOVER;
                    cnt_next   = CNT_W'(RECOVER_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (phase_done) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        window_next = (state_next == SETUP) || (state_next == STROBE) ||
                      (state_next == HOLD);
        // Read data is sampled on the edge that closes the final strobe cycle.
        capture     = (state_reg == STROBE) && phase_done && !write_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            write_reg    <= 1'b0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            otg_addr     <= 2'd0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_out <= 16'h0000;
            otg_data_oe  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            write_reg   <= write_next;
            cmd_ready   <= (state_next == IDLE);
            busy        <= (state_next != IDLE);
            rsp_valid   <= (state_reg == HOLD) && (state_next == RECOVER);
            otg_cs_n    <= !window_next;
            otg_rd_n    <= !((state_next == STROBE) && !write_next);
            otg_wr_n    <= !((state_next == STROBE) && write_next);
            // Only drive the pad during our own write window, so the chip
            // and the FPGA never fight over the data bus.
            otg_data_oe <= window_next && write_next;
            if (accept) begin
                otg_addr <= cmd_addr;
                if (cmd_write) begin
                    otg_data_out <= cmd_wdata;
                end
            end
            if (capture) begin
                rsp_rdata <= otg_data_in;
            end
        end
    end

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Bench for hpi_access_sequencer: instance 0 uses default timing, instance 1
// uses single-cycle phases. Expected pin waveforms come from a cycle-offset
// model of the bus cycle (window = setup+strobe+hold, then recovery).
module tb_hpi_access_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid   [2];
    logic        cmd_write   [2];
    logic [1:0]  cmd_addr    [2];
    logic [15:0] cmd_wdata   [2];
    logic [15:0] otg_data_in [2];
    logic        cmd_ready   [2];
    logic        rsp_valid   [2];
    logic [15:0] rsp_rdata   [2];
    logic        busy        [2];
    logic [1:0]  otg_addr    [2];
    logic        otg_cs_n    [2];
    logic        otg_rd_n    [2];
    logic        otg_wr_n    [2];
    logic [15:0] otg_data_out[2];
    logic        otg_data_oe [2];

    always #5 clk = ~clk;

    hpi_access_sequencer dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .otg_addr(otg_addr[0]), .otg_cs_n(otg_cs_n[0]), .otg_rd_n(otg_rd_n[0]),
        .otg_wr_n(otg_wr_n[0]), .otg_data_out(otg_data_out[0]),
        .otg_data_oe(otg_data_oe[0]), .otg_data_in(otg_data_in[0])
    );

    hpi_access_sequencer #(
        .CNT_W(4), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .otg_addr(otg_addr[1]), .otg_cs_n(otg_cs_n[1]), .otg_rd_n(otg_rd_n[1]),
        .otg_wr_n(otg_wr_n[1]), .otg_data_out(otg_data_out[1]),
        .otg_data_oe(otg_data_oe[1]), .otg_data_in(otg_data_in[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    int s_cyc [2] = '{2, 1};
    int st_cyc[2] = '{4, 1};
    int h_cyc [2] = '{1, 1};
    int r_cyc [2] = '{3, 1};

    logic [15:0] model_rdata[2];

    typedef struct {
        int          d;
        bit          w;
        logic [1:0]  a;
        logic [15:0] wd;
        bit          directed;
        bit          hold;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called in the middle of a cycle (at a falling edge). Issues one command,
    // then checks every cycle from the first pin cycle through the cycle where
    // cmd_ready returns. Leaves the bench at that cycle's falling edge.
    task automatic run_cmd(input int d, input bit w, input logic [1:0] a,
                           input logic [15:0] wd, input bit directed,
                           input bit hold_valid, input bit expect_now);
        int waited = 0;
        int s   = s_cyc[d];
        int st  = st_cyc[d];
        int win = s_cyc[d] + st_cyc[d] + h_cyc[d];
        int last = win + r_cyc[d] + 1;
        logic [15:0] captured = model_rdata[d];
        bit in_win, in_strobe;

        cmd_valid[d] = 1'b1;
        cmd_write[d] = w;
        cmd_addr[d]  = a;
        cmd_wdata[d] = wd;
        if (directed) otg_data_in[d] = 16'hBEEF;
        while (cmd_ready[d] !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready[d] !== 1'b1) begin
            check("accept_timeout", 16'(cmd_ready[d]), 16'd1);
            cmd_valid[d] = 1'b0;
            return;
        end
        if (expect_now) check("b2b_accept_wait", 16'(waited), 16'd0);

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1 && !hold_valid) cmd_valid[d] = 1'b0;
            in_win    = (c <= win);
            in_strobe = (c > s) && (c <= s + st);
            check("cs_n",      16'(otg_cs_n[d]),    16'(!in_win));
            check("rd_n",      16'(otg_rd_n[d]),    16'(!(in_strobe && !w)));
            check("wr_n",      16'(otg_wr_n[d]),    16'(!(in_strobe && w)));
            check("oe",        16'(otg_data_oe[d]), 16'(in_win && w));
            check("busy",      16'(busy[d]),        16'(c < last));
            check("cmd_ready", 16'(cmd_ready[d]),   16'(c == last));
            check("rsp_valid", 16'(rsp_valid[d]),   16'(c == win + 1));
            if (in_win) check("otg_addr", 16'(otg_addr[d]), 16'(a));
            if (in_win && w) check("data_out", otg_data_out[d], wd);
            check("rsp_rdata", rsp_rdata[d],
                  (!w && c > s + st) ? captured : model_rdata[d]);
            if (directed) otg_data_in[d] = (c < s + st) ? 16'hBEEF : 16'h5555;
            else          otg_data_in[d] = 16'($urandom);
            if (directed && c == s + st) otg_data_in[d] = 16'hBEEF;
            if (c == s + st && !w) captured = otg_data_in[d];
        end
        if (!w) model_rdata[d] = captured;
    endtask

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 1'b1, 2'd2, 16'h1234, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
        tbl[2] = '{0, 1'b1, 2'd3, 16'hCAFE, 1'b0, 1'b1, 16'hBEEF};
        tbl[3] = '{0, 1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
        tbl[4] = '{0, 1'b1, 2'd0, 16'hFFFF, 1'b0, 1'b0, 16'hBEEF};
        tbl[5] = '{1, 1'b1, 2'd2, 16'h0F0F, 1'b0, 1'b0, 16'h0000};
        tbl[6] = '{1, 1'b0, 2'd3, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
        tbl[7] = '{1, 1'b1, 2'd1, 16'h7777, 1'b0, 1'b0, 16'hBEEF};

        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0; cmd_addr[d] = 2'd0;
            cmd_wdata[d] = 16'h0; otg_data_in[d] = 16'h0; model_rdata[d] = 16'h0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_cs_n",      16'(otg_cs_n[d]),    16'd1);
            check("rst_rd_n",      16'(otg_rd_n[d]),    16'd1);
            check("rst_wr_n",      16'(otg_wr_n[d]),    16'd1);
            check("rst_oe",        16'(otg_data_oe[d]), 16'd0);
            check("rst_addr",      16'(otg_addr[d]),    16'd0);
            check("rst_data_out",  otg_data_out[d],     16'h0000);
            check("rst_rsp_valid", 16'(rsp_valid[d]),   16'd0);
            check("rst_rsp_rdata", rsp_rdata[d],        16'h0000);
            check("rst_busy",      16'(busy[d]),        16'd0);
            check("rst_cmd_ready", 16'(cmd_ready[d]),   16'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready0", 16'(cmd_ready[0]), 16'd1);
        check("post_rst_ready1", 16'(cmd_ready[1]), 16'd1);

        // Directed vectors, including a held-valid write->read pair
        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].directed,
                    tbl[i].hold, (i > 0) && tbl[i-1].hold && (tbl[i-1].d == tbl[i].d));
            check("tbl_rdata", rsp_rdata[tbl[i].d], tbl[i].exp_rdata);
            $display("vector %0d: dut%0d %s addr=%0d rdata=%h", i, tbl[i].d,
                     tbl[i].w ? "write" : "read", tbl[i].a, rsp_rdata[tbl[i].d]);
        end

        // Reset in the middle of a write strobe
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 2'd1; cmd_wdata[0] = 16'hA5A5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid[0] = 1'b0;
        end
        check("pre_rst_wr_n", 16'(otg_wr_n[0]), 16'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_wr_n",  16'(otg_wr_n[0]),    16'd1);
        check("midrst_cs_n",  16'(otg_cs_n[0]),    16'd1);
        check("midrst_oe",    16'(otg_data_oe[0]), 16'd0);
        check("midrst_busy",  16'(busy[0]),        16'd0);
        check("midrst_ready", 16'(cmd_ready[0]),   16'd0);
        check("midrst_rdata", rsp_rdata[0],        16'h0000);
        model_rdata[0] = 16'h0000;
        model_rdata[1] = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            check("midrst_rsp_valid", 16'(rsp_valid[0]), 16'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", 16'(cmd_ready[0]), 16'd1);
        check("midrst_release_rsp",   16'(rsp_valid[0]), 16'd0);
        run_cmd(0, 1'b0, 2'd3, 16'h0, 1'b0, 1'b0, 1'b0);
        $display("post-reset read: rdata=%h", rsp_rdata[0]);

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            bit prev_hold = 1'b0;
            for (int i = 0; i < 15; i++) begin
                bit          w    = 1'($urandom);
                logic [1:0]  a    = 2'($urandom);
                logic [15:0] wd   = 16'($urandom);
                bit          hold = (i < 14) ? 1'($urandom) : 1'b0;
                if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
                run_cmd(d, w, a, wd, 1'b0, hold, prev_hold);
                $display("random dut%0d #%0d: %s addr=%0d wdata=%h rdata=%h", d, i,
                         w ? "write" : "read", a, wd, rsp_rdata[d]);
                prev_hold = hold;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
